// File: rtl/dmem_pkg.sv
// Shared constants for the data-memory responder: FSM encoding and latency counter sizing.
package dmem_pkg;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_WAIT = 2'd1;
  localparam logic [1:0] ST_RESP = 2'd2;

  localparam int LAT_MAX = 15;
  localparam int CNT_W   = 4;

  typedef logic [CNT_W-1:0] cnt_t;

endpackage

// File: rtl/dmem_lat_counter.sv
// Loadable down-counter; term_o flags the final WAIT cycle (count == 1) so the
// access and the WAIT-to-RESP move happen on the same edge.
module dmem_lat_counter
  import dmem_pkg::*;
(
  input  logic clk,
  input  logic rst,
  input  logic load_i,
  input  cnt_t load_val_i,
  input  logic dec_i,
  output logic term_o
);

  cnt_t cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load_i)
      cnt_d = load_val_i;
    else if (dec_i && (cnt_q != '0))
      cnt_d = cnt_q - 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      cnt_q <= '0;
    else
      cnt_q <= cnt_d;
  end

  assign term_o = (cnt_q == cnt_t'(1));

endmodule

// File: rtl/dmem_responder.sv
// Multi-cycle data-memory responder: one request at a time, fixed latency, one-cycle response.
// Define DMEM_MISALIGN_CHECK_EN to flag and suppress accesses with req_addr[1:0] != 0.
module dmem_responder
  import dmem_pkg::*;
#(
  parameter int WIDTH     = 32,
  parameter int ADDR_BITS = 8,
  parameter int LATENCY   = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req_valid,
  input  logic             req_write,
  input  logic [31:0]      req_addr,
  input  logic [WIDTH-1:0] req_wdata,
  output logic             req_ready,
  output logic             resp_valid,
  output logic [WIDTH-1:0] resp_rdata,
  output logic             resp_err,
  output logic             stall
);

  if ((LATENCY < 1) || (LATENCY > LAT_MAX)) begin : g_bad_latency
    $error("dmem_responder: LATENCY must lie in 1..15");
  end

  logic [1:0]           state_q, state_d;
  logic                 write_q;
  logic [ADDR_BITS-1:0] idx_q;
  logic [WIDTH-1:0]     wdata_q;
  logic                 mis_q;
  logic [WIDTH-1:0]     rdata_q;
  logic                 err_q;
  logic [WIDTH-1:0]     mem [2**ADDR_BITS];

  logic                 accept;
  logic                 req_mis;
  logic                 cnt_term;
  logic                 access;
  logic                 acc_write;
  logic                 acc_mis;
  logic [ADDR_BITS-1:0] acc_idx;
  logic [WIDTH-1:0]     acc_wdata;

`ifdef DMEM_MISALIGN_CHECK_EN
  logic unused_addr;
  assign req_mis     = |req_addr[1:0];
  assign unused_addr = ^req_addr[31:ADDR_BITS+2];
`else
  logic unused_addr;
  assign req_mis     = 1'b0;
  assign unused_addr = ^{req_addr[31:ADDR_BITS+2], req_addr[1:0]};
`endif

  assign accept = (state_q == ST_IDLE) && req_valid;

  // With LATENCY=1 the access happens on the accept edge itself, so it uses the live request.
  assign access    = (accept && (LATENCY == 1)) || ((state_q == ST_WAIT) && cnt_term);
  assign acc_write = (state_q == ST_IDLE) ? req_write : write_q;
  assign acc_mis   = (state_q == ST_IDLE) ? req_mis : mis_q;
  assign acc_idx   = (state_q == ST_IDLE) ? req_addr[ADDR_BITS+1:2] : idx_q;
  assign acc_wdata = (state_q == ST_IDLE) ? req_wdata : wdata_q;

  dmem_lat_counter u_lat_counter (
    .clk        (clk),
    .rst        (rst),
    .load_i     (accept),
    .load_val_i (cnt_t'(LATENCY - 1)),
    .dec_i      ((state_q == ST_WAIT) && !cnt_term),
    .term_o     (cnt_term)
  );

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (req_valid) state_d = (LATENCY == 1) ? ST_RESP : ST_WAIT;
      ST_WAIT: if (cnt_term) state_d = ST_RESP;
      ST_RESP: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      write_q <= 1'b0;
      idx_q   <= '0;
      wdata_q <= '0;
      mis_q   <= 1'b0;
      rdata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        write_q <= req_write;
        idx_q   <= req_addr[ADDR_BITS+1:2];
        wdata_q <= req_wdata;
        mis_q   <= req_mis;
      end
      if (access) begin
        rdata_q <= (acc_write || acc_mis) ? '0 : mem[acc_idx];
        err_q   <= acc_mis;
      end
    end
  end

  // Array is left out of reset; a reset before the access edge simply drops the store.
  always_ff @(posedge clk) begin
    if (access && acc_write && !acc_mis && !rst)
      mem[acc_idx] <= acc_wdata;
  end

  assign req_ready  = (state_q == ST_IDLE);
  assign resp_valid = (state_q == ST_RESP);
  assign resp_rdata = rdata_q;
  assign resp_err   = err_q;
  assign stall      = (state_q == ST_WAIT) || accept;

endmodule
